// File: rtl/key_scan_pkg.sv
// Shared types and helpers for the keypad scanner: debounce states,
// frame classification and the matrix geometry.
package key_scan_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int CODE_W   = 4;
    localparam int FRAME_W  = NUM_ROWS * NUM_COLS;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        DEB_PRESS   = 2'd1,
        PRESSED     = 2'd2,
        DEB_RELEASE = 2'd3
    } deb_state_t;

    typedef enum logic [1:0] {
        CLS_NONE   = 2'd0,
        CLS_SINGLE = 2'd1,
        CLS_MULTI  = 2'd2
    } frame_class_t;

    function automatic frame_class_t classify_frame(input logic [FRAME_W-1:0] bits);
        int ones;
        ones = 0;
        for (int i = 0; i < FRAME_W; i++) begin
            if (bits[i]) ones++;
        end
        if (ones == 0)      return CLS_NONE;
        else if (ones == 1) return CLS_SINGLE;
        else                return CLS_MULTI;
    endfunction

    // Only meaningful for a SINGLE frame, where exactly one bit can match.
    function automatic logic [CODE_W-1:0] frame_key_code(input logic [FRAME_W-1:0] bits);
        logic [CODE_W-1:0] code;
        code = '0;
        for (int i = 0; i < FRAME_W; i++) begin
            if (bits[i]) code = CODE_W'(i);
        end
        return code;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Frame-level debounce FSM: confirms a single key press over several
// identical frames and tracks its release the same way.
module key_debounce
    import key_scan_pkg::*;
#(
    parameter int DEBOUNCE_FRAMES = 5
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              frame_done,
    input  frame_class_t      frame_class,
    input  logic [CODE_W-1:0] frame_code,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    output logic              key_down
);

    localparam logic [3:0] DEB_TARGET = 4'(DEBOUNCE_FRAMES);

    deb_state_t        state, state_nxt;
    logic [CODE_W-1:0] cand, cand_nxt;
    logic [3:0]        cnt, cnt_nxt;
    logic [3:0]        cnt_inc;
    logic [CODE_W-1:0] code_nxt;
    logic              valid_nxt;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            cand      <= '0;
            cnt       <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            cand      <= cand_nxt;
            cnt       <= cnt_nxt;
            key_code  <= code_nxt;
            key_valid <= valid_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cand_nxt  = cand;
        cnt_nxt   = cnt;
        code_nxt  = key_code;
        valid_nxt = 1'b0;
        cnt_inc   = cnt + 4'd1;
        if (frame_done) begin
            unique case (state)
                IDLE: begin
                    if (frame_class == CLS_SINGLE) begin
                        state_nxt = DEB_PRESS;
                        cand_nxt  = frame_code;
                        cnt_nxt   = 4'd1;
                    end
                end
                DEB_PRESS: begin
                    if (frame_class == CLS_SINGLE && frame_code == cand) begin
                        cnt_nxt = cnt_inc;
                        if (cnt_inc == DEB_TARGET) begin
                            state_nxt = PRESSED;
                            code_nxt  = cand;
                            valid_nxt = 1'b1;
                        end
                    end else if (frame_class == CLS_SINGLE) begin
                        cand_nxt = frame_code;
                        cnt_nxt  = 4'd1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
                PRESSED: begin
                    // Extra keys while held are ignored; only a clean NONE starts release.
                    if (frame_class == CLS_NONE) begin
                        state_nxt = DEB_RELEASE;
                        cnt_nxt   = 4'd1;
                    end
                end
                DEB_RELEASE: begin
                    if (frame_class == CLS_NONE) begin
                        cnt_nxt = cnt_inc;
                        if (cnt_inc == DEB_TARGET) state_nxt = IDLE;
                    end else begin
                        state_nxt = PRESSED;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        key_down = (state == PRESSED) || (state == DEB_RELEASE);
    end

endmodule

// File: rtl/key_scan.sv
// 4x4 keypad scanner top: row strobing, column synchronizer and
// per-frame snapshot feeding the debounce FSM.
module key_scan
    import key_scan_pkg::*;
#(
    parameter int MCNT_TICK       = 49999,
    parameter int DEBOUNCE_FRAMES = 5
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [NUM_COLS-1:0] Col,
    output logic [NUM_ROWS-1:0] Row,
    output logic [CODE_W-1:0] Key_Code,
    output logic              Key_Valid,
    output logic              Key_Down
);

    localparam int TICK_W = (MCNT_TICK < 1) ? 1 : $clog2(MCNT_TICK + 1);

    logic [TICK_W-1:0]   tick_cnt;
    logic                tick;
    logic [1:0]          row_ptr;
    logic [1:0]          row_next;
    logic [NUM_COLS-1:0] col_meta;
    logic [NUM_COLS-1:0] col_sync;
    logic [FRAME_W-1:0]  snapshot;
    logic [FRAME_W-1:0]  frame_bits;
    logic                frame_done;
    frame_class_t        frame_class;
    logic [CODE_W-1:0]   frame_code;

    assign tick     = (tick_cnt == TICK_W'(MCNT_TICK));
    assign row_next = row_ptr + 2'd1;

    // Columns are sampled at the end of each row period so they have settled.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            tick_cnt <= '0;
            row_ptr  <= '0;
            Row      <= 4'b1110;
            col_meta <= '1;
            col_sync <= '1;
            snapshot <= '0;
        end else begin
            col_meta <= Col;
            col_sync <= col_meta;
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            if (tick) begin
                snapshot[{row_ptr, 2'b00} +: NUM_COLS] <= ~col_sync;
                row_ptr <= row_next;
                Row     <= ~(4'b0001 << row_next);
            end
        end
    end

    // The row being sampled this tick is merged in so the FSM sees the full frame now.
    always_comb begin
        frame_bits = snapshot;
        frame_bits[{row_ptr, 2'b00} +: NUM_COLS] = ~col_sync;
        frame_done  = tick && (row_ptr == 2'd3);
        frame_class = classify_frame(frame_bits);
        frame_code  = frame_key_code(frame_bits);
    end

    key_debounce #(
        .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
    ) u_debounce (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_done (frame_done),
        .frame_class(frame_class),
        .frame_code (frame_code),
        .key_code   (Key_Code),
        .key_valid  (Key_Valid),
        .key_down   (Key_Down)
    );

endmodule

// File: tb/tb_key_scan.sv
// Directed bench for key_scan with a modelled 4x4 keypad, a 16-cycle
// frame and three-frame debounce.
module tb_key_scan;

    localparam int FRAME_CYC = 16;

    logic        Clk;
    logic        Reset;
    logic [3:0]  Col;
    logic [3:0]  Row;
    logic [3:0]  Key_Code;
    logic        Key_Valid;
    logic        Key_Down;

    logic [15:0] keys;
    int          checks;
    int          passes;
    int          pulses;
    int          double_pulse;
    int          down_seen;
    logic        prev_valid;
    logic [3:0]  last_code;

    key_scan #(
        .MCNT_TICK      (3),
        .DEBOUNCE_FRAMES(3)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Col      (Col),
        .Row      (Row),
        .Key_Code (Key_Code),
        .Key_Valid(Key_Valid),
        .Key_Down (Key_Down)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // A pressed key shorts its column to its row while that row is driven low.
    always_comb begin
        Col = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !Row[r]) Col[c] = 1'b0;
            end
        end
    end

    always @(negedge Clk) begin
        if (Key_Valid) begin
            pulses++;
            last_code = Key_Code;
            if (prev_valid) double_pulse++;
        end
        prev_valid = Key_Valid;
        if (Key_Down) down_seen = 1;
    end

    task automatic applyStimulus(input logic [15:0] k);
        keys = k;
    endtask

    task automatic stepCycles(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic stepFrames(input int n);
        stepCycles(n * FRAME_CYC);
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checks++;
        assert (observed === expected) passes++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    initial begin
        checks = 0; passes = 0; pulses = 0; double_pulse = 0; down_seen = 0;
        prev_valid = 1'b0; last_code = 4'h0;
        keys  = 16'h0000;
        Reset = 1'b1;
        stepCycles(2);
        checkOutput("reset_row", 16'(Row), 16'h000E);
        checkOutput("reset_code", 16'(Key_Code), 16'h0000);
        checkOutput("reset_valid", 16'(Key_Valid), 16'h0000);
        checkOutput("reset_down", 16'(Key_Down), 16'h0000);
        Reset = 1'b0;
        stepCycles(3);
        checkOutput("row0_hold", 16'(Row), 16'h000E);
        stepCycles(1);
        checkOutput("row1", 16'(Row), 16'h000D);
        stepCycles(4);
        checkOutput("row2", 16'(Row), 16'h000B);
        stepCycles(4);
        checkOutput("row3", 16'(Row), 16'h0007);
        stepCycles(4);
        checkOutput("row_wrap", 16'(Row), 16'h000E);

        $display("[TB] single press of key 9");
        applyStimulus(16'h0200);
        stepFrames(2);
        checkOutput("k9_early_valid", 16'(Key_Valid), 16'h0000);
        checkOutput("k9_early_down", 16'(Key_Down), 16'h0000);
        stepFrames(1);
        checkOutput("k9_valid", 16'(Key_Valid), 16'h0001);
        checkOutput("k9_down", 16'(Key_Down), 16'h0001);
        checkOutput("k9_code", 16'(Key_Code), 16'h0009);
        stepCycles(1);
        checkOutput("k9_valid_drop", 16'(Key_Valid), 16'h0000);
        stepCycles(FRAME_CYC - 1);
        stepFrames(2);
        checkOutput("k9_held_down", 16'(Key_Down), 16'h0001);
        applyStimulus(16'h0000);
        stepFrames(2);
        checkOutput("k9_rel_down", 16'(Key_Down), 16'h0001);
        stepFrames(1);
        checkOutput("k9_released", 16'(Key_Down), 16'h0000);
        checkOutput("k9_pulses", 16'(pulses), 16'd1);
        checkOutput("k9_pulse_code", 16'(last_code), 16'h0009);

        $display("[TB] bouncing key 9");
        down_seen = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(16'h0200);
            stepFrames(1);
            applyStimulus(16'h0000);
            stepFrames(1);
        end
        checkOutput("bounce_pulses", 16'(pulses), 16'd1);
        checkOutput("bounce_down_seen", 16'(down_seen), 16'd0);

        $display("[TB] multi-key then key 3 plus key C");
        applyStimulus(16'h0021);
        stepFrames(5);
        checkOutput("multi_pulses", 16'(pulses), 16'd1);
        checkOutput("multi_down_seen", 16'(down_seen), 16'd0);
        applyStimulus(16'h0008);
        stepFrames(2);
        checkOutput("k3_early_valid", 16'(Key_Valid), 16'h0000);
        stepFrames(1);
        checkOutput("k3_valid", 16'(Key_Valid), 16'h0001);
        checkOutput("k3_code", 16'(Key_Code), 16'h0003);
        stepCycles(1);
        checkOutput("k3_valid_drop", 16'(Key_Valid), 16'h0000);
        stepCycles(FRAME_CYC - 1);
        applyStimulus(16'h1008);
        stepFrames(3);
        checkOutput("k3c_pulses", 16'(pulses), 16'd2);
        checkOutput("k3c_code", 16'(Key_Code), 16'h0003);
        checkOutput("k3c_down", 16'(Key_Down), 16'h0001);
        checkOutput("k3c_pulse_code", 16'(last_code), 16'h0003);
        applyStimulus(16'h0000);
        stepFrames(3);
        checkOutput("k3_released", 16'(Key_Down), 16'h0000);

        $display("[TB] reset during debounce of key F");
        applyStimulus(16'h8000);
        stepFrames(2);
        checkOutput("kf_pre_down", 16'(Key_Down), 16'h0000);
        Reset = 1'b1;
        stepCycles(2);
        checkOutput("kf_rst_row", 16'(Row), 16'h000E);
        checkOutput("kf_rst_code", 16'(Key_Code), 16'h0000);
        checkOutput("kf_rst_valid", 16'(Key_Valid), 16'h0000);
        checkOutput("kf_rst_down", 16'(Key_Down), 16'h0000);
        Reset = 1'b0;
        stepFrames(2);
        checkOutput("kf_early_valid", 16'(Key_Valid), 16'h0000);
        checkOutput("kf_early_down", 16'(Key_Down), 16'h0000);
        checkOutput("kf_rst_pulses", 16'(pulses), 16'd2);
        stepFrames(1);
        checkOutput("kf_valid", 16'(Key_Valid), 16'h0001);
        checkOutput("kf_code", 16'(Key_Code), 16'h000F);
        checkOutput("kf_down", 16'(Key_Down), 16'h0001);
        stepCycles(FRAME_CYC);

        $display("[TB] re-press during release debounce");
        applyStimulus(16'h0000);
        stepFrames(1);
        checkOutput("rel1_down", 16'(Key_Down), 16'h0001);
        applyStimulus(16'h0200);
        stepFrames(1);
        checkOutput("repress_down", 16'(Key_Down), 16'h0001);
        checkOutput("repress_valid", 16'(Key_Valid), 16'h0000);
        applyStimulus(16'h0000);
        stepFrames(2);
        checkOutput("rel2_down", 16'(Key_Down), 16'h0001);
        stepFrames(1);
        checkOutput("final_down", 16'(Key_Down), 16'h0000);
        checkOutput("final_pulses", 16'(pulses), 16'd3);
        checkOutput("final_code", 16'(Key_Code), 16'h000F);
        checkOutput("no_double_pulse", 16'(double_pulse), 16'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
